// File: rtl/int8_output_packer_pkg.sv
// Shared constants and types for the int8 output packer and its requantizer neighbour.
// Holds the int8 range, the lane geometry and the packed FIFO word layout.
package int8_output_packer_pkg;

  localparam int INT8_MIN = -128;
  localparam int INT8_MAX = 127;
  localparam int LANES    = 4;
  localparam int LANE_W   = 8;
  localparam int WORD_W   = LANES * LANE_W;

  // FIFO entry layout: {last, keep, data}, 37 bits.
  typedef struct packed {
    logic               last;
    logic [LANES-1:0]   keep;
    logic [WORD_W-1:0]  data;
  } word_t;

  // Lower bound first, then upper bound, so an inverted range yields hi.
  function automatic logic signed [8:0] clamp9(input logic signed [8:0] v,
                                               input logic signed [8:0] lo,
                                               input logic signed [8:0] hi);
    logic signed [8:0] t;
    t = (v < lo) ? lo : v;
    return (t > hi) ? hi : t;
  endfunction

endpackage

// File: rtl/int8_output_packer_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; a push into a full FIFO is
// accepted only when a pop happens in the same cycle, otherwise it is ignored.
module int8_output_packer_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wdata_i;
  end

  // Empty head reads as zero so the outputs show a clean value after reset.
  assign rdata_o = empty_o ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/int8_output_packer.sv
// Adds the output zero point, applies the activation clamp and packs four int8
// lanes little-endian into 32-bit words queued for a ready/valid consumer.
// Optional feature: define PACKER_SAT_CNT_EN to add the sat_count port and counter.
module int8_output_packer
  import int8_output_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic [7:0]  output_zero_point,
  input  logic [7:0]  act_min,
  input  logic [7:0]  act_max,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_keep,
  output logic        out_last,
  output logic        overflow
`ifdef PACKER_SAT_CNT_EN
 ,output logic [15:0] sat_count
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Stage A: offset and clamp, registered.
  logic signed [8:0] sum, y9;
  logic              a_valid_q, a_last_q;
  logic [7:0]        a_y_q;

  assign sum = $signed({in_data[7], in_data}) +
               $signed({output_zero_point[7], output_zero_point});
  assign y9  = clamp9(sum, $signed({act_min[7], act_min}), $signed({act_max[7], act_max}));

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_valid_q <= 1'b0;
      a_last_q  <= 1'b0;
      a_y_q     <= '0;
    end else begin
      a_valid_q <= in_valid;
      if (in_valid) begin
        a_y_q    <= y9[7:0];
        a_last_q <= in_last;
      end
    end
  end

  // Stage B: lane assembly; the byte that completes a word is merged combinationally.
  logic [1:0]         cnt_q, cnt_d;
  logic [WORD_W-1:0]  lane_data_q, lane_data_d, word_data;
  logic [LANES-1:0]   lane_keep_q, lane_keep_d, word_keep;
  logic               emit;

  always_comb begin
    word_data = lane_data_q;
    word_data[{cnt_q, 3'b000} +: LANE_W] = a_y_q;
    word_keep   = lane_keep_q | (4'b0001 << cnt_q);
    emit        = a_valid_q && ((cnt_q == 2'd3) || a_last_q);
    cnt_d       = cnt_q;
    lane_data_d = lane_data_q;
    lane_keep_d = lane_keep_q;
    if (a_valid_q) begin
      if (emit) begin
        cnt_d       = 2'd0;
        lane_data_d = '0;
        lane_keep_d = '0;
      end else begin
        cnt_d       = cnt_q + 2'd1;
        lane_data_d = word_data;
        lane_keep_d = word_keep;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q       <= '0;
      lane_data_q <= '0;
      lane_keep_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      lane_data_q <= lane_data_d;
      lane_keep_q <= lane_keep_d;
    end
  end

  // Output word FIFO.
  word_t              push_word, head_word;
  logic [$bits(word_t)-1:0] fifo_rdata;
  logic               fifo_full, fifo_empty, pop, drop;
  logic [CNT_W-1:0]   fifo_count;
  logic               overflow_q;

  assign push_word = '{last: a_last_q, keep: word_keep, data: word_data};

  int8_output_packer_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(word_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (emit),
    .wdata_i (push_word),
    .pop_i   (out_ready),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head_word = fifo_rdata;
  assign out_valid = !fifo_empty;
  assign out_data  = head_word.data;
  assign out_keep  = head_word.keep;
  assign out_last  = head_word.last;

  assign pop  = out_valid && out_ready;
  assign drop = emit && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (!rst)      overflow_q <= 1'b0;
    else if (drop) overflow_q <= 1'b1;
  end
  assign overflow = overflow_q;

  full_matches_count: assert property (@(posedge clk) disable iff (!rst)
    fifo_full == (fifo_count == CNT_W'(FIFO_DEPTH)));

`ifdef PACKER_SAT_CNT_EN
  logic        clamped;
  logic [15:0] sat_count_q;

  assign clamped = (y9 != sum);

  always_ff @(posedge clk) begin
    if (!rst)
      sat_count_q <= '0;
    else if (in_valid && clamped && (sat_count_q != 16'hFFFF))
      sat_count_q <= sat_count_q + 16'd1;
  end
  assign sat_count = sat_count_q;
`endif

endmodule
